matrix_add_sub: RTL and testbench

Module-bus responder that adds or subtracts two 4x4 matrices of 16-bit elements on behalf of the execution engine. It is the responder end of the engine's module-bus handshake (enable / read-write / 256-bit data in / 256-bit data out / done flag), and it uses the same signalling as the multiply unit. The engine writes operand A, then operand B together with the add/subtract select, polls the flag, and reads back the 256-bit result. It attaches to the engine's add/sub enable, read-write and flag lines and to the shared module buses.

---
 rtl/matrix_add_sub.sv | 105 ++++++++++
 tb/tb_matrix_add_sub.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/matrix_add_sub.sv
// ============================================================================
// matrix_add_sub : module-bus responder computing A+B or A-B on 4x4 matrices
// Revision: 1.0
// ============================================================================
`default_nettype none

module matrix_add_sub #(
  parameter int ELEM_W = 16,
  parameter int LANES  = 4
) (
  input  logic                 clk,
  input  logic                 RESET,
  input  logic [16*ELEM_W-1:0] data_in,
  input  logic                 rw,
  input  logic                 en,
  input  logic                 add1sub0,
  output logic [16*ELEM_W-1:0] data_out,
  output logic                 flag
);

  localparam int BUS_W = 16 * ELEM_W;
  localparam int NGRP  = 16 / LANES;
  localparam int CW    = (NGRP > 1) ? $clog2(NGRP) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HAVE_A  = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state_q;
  logic [BUS_W-1:0]  a_q, b_q, res_q, res_d;
  logic              op_q, flag_q;
  logic [CW-1:0]     cnt_q;
  logic [ELEM_W-1:0] ea, eb;

  // Subtraction is A + ~B + 1; the carry-in is the inverted op bit.
  always_comb begin
    res_d = res_q;
    ea    = '0;
    eb    = '0;
    for (int j = 0; j < LANES; j++) begin
      ea = a_q[(int'(cnt_q) * LANES + j) * ELEM_W +: ELEM_W];
      eb = b_q[(int'(cnt_q) * LANES + j) * ELEM_W +: ELEM_W];
      res_d[(int'(cnt_q) * LANES + j) * ELEM_W +: ELEM_W] =
        ea + (op_q ? eb : ~eb) + {{(ELEM_W-1){1'b0}}, ~op_q};
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= 1'b0;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en && rw) begin
            a_q     <= data_in;
            state_q <= HAVE_A;
          end
        end
        HAVE_A: begin
          if (en && rw) begin
            b_q     <= data_in;
            op_q    <= add1sub0;
            cnt_q   <= '0;
            state_q <= COMPUTE;
          end
        end
        COMPUTE: begin
          res_q <= res_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(NGRP - 1)) begin
            state_q <= DONE;
            flag_q  <= 1'b1;
          end
        end
        DONE: begin
          if (en) begin
            flag_q <= 1'b0;
            if (rw) begin
              a_q     <= data_in;
              state_q <= HAVE_A;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out = res_q;
  assign flag     = flag_q;

endmodule

`default_nettype wire

// File: tb/tb_matrix_add_sub.sv
// ============================================================================
// tb_matrix_add_sub : directed + randomized self-checking bench for matrix_add_sub
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_matrix_add_sub;

  logic         clk = 1'b0;
  logic         RESET = 1'b1;
  logic [255:0] data_in = '0;
  logic         rw = 1'b0;
  logic         en = 1'b0;
  logic         add1sub0 = 1'b0;
  logic [255:0] data_out;
  logic         flag;

  int tests = 0;
  int fails = 0;

  matrix_add_sub dut (
    .clk      (clk),
    .RESET    (RESET),
    .data_in  (data_in),
    .rw       (rw),
    .en       (en),
    .add1sub0 (add1sub0),
    .data_out (data_out),
    .flag     (flag)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] model(input logic [255:0] a, input logic [255:0] b,
                                         input logic add);
    logic [255:0] r;
    logic [15:0]  ea, eb, s;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      ea = a[i*16 +: 16];
      eb = b[i*16 +: 16];
      s  = add ? 16'(ea + eb) : 16'(ea - eb);
      r[i*16 +: 16] = s;
    end
    return r;
  endfunction

  function automatic logic [255:0] rand_mat();
    logic [255:0] m;
    for (int i = 0; i < 8; i++) m[i*32 +: 32] = $urandom;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic write_a(input logic [255:0] a);
    en = 1'b1; rw = 1'b1; data_in = a;
    tick();
    en = 1'b0; rw = 1'b0;
  endtask

  task automatic write_b(input logic [255:0] b, input logic add);
    en = 1'b1; rw = 1'b1; data_in = b; add1sub0 = add;
    tick();
    en = 1'b0; rw = 1'b0;
  endtask

  task automatic do_read(input string tag);
    en = 1'b1; rw = 1'b0;
    tick();
    en = 1'b0;
    check({tag, " flag_after_read"}, 256'(flag), 256'(0));
  endtask

  // Waits for flag after a B write; optionally hammers the bus while computing.
  task automatic wait_result(input string tag, input logic noisy, input logic [255:0] exp);
    int cyc;
    cyc = 0;
    while (flag !== 1'b1 && cyc < 20) begin
      if (noisy) begin
        en = 1'b1; rw = 1'($urandom); data_in = rand_mat(); add1sub0 = 1'($urandom);
      end
      tick();
      cyc++;
    end
    en = 1'b0; rw = 1'b0;
    check({tag, " latency"}, 256'(cyc), 256'(4));
    check({tag, " result"}, data_out, exp);
  endtask

  logic [255:0] a, b, exp, a2;
  logic         op;

  initial begin
    // Reset state
    tick(); tick();
    RESET = 1'b0;
    check("reset flag", 256'(flag), 256'(0));
    check("reset data", data_out, 256'(0));

    // Add 3 + 5
    a = {16{16'h0003}}; b = {16{16'h0005}};
    write_a(a); write_b(b, 1'b1);
    wait_result("add35", 1'b0, {16{16'h0008}});
    do_read("add35");

    // Subtract with wrap in element 0
    a = {16{16'h1234}}; b = {16{16'h0034}};
    a[15:0] = 16'h0000; b[15:0] = 16'h0001;
    exp = {16{16'h1200}}; exp[15:0] = 16'hFFFF;
    write_a(a); write_b(b, 1'b0);
    wait_result("subwrap", 1'b0, exp);
    do_read("subwrap");

    // Add overflow and element packing
    for (int i = 0; i < 16; i++) begin
      a[i*16 +: 16]   = 16'hFFF0 + 16'(i);
      b[i*16 +: 16]   = 16'h0020;
      exp[i*16 +: 16] = 16'h0010 + 16'(i);
    end
    write_a(a); write_b(b, 1'b1);
    wait_result("ovfpack", 1'b0, exp);
    // DONE holds flag while idle
    repeat (5) tick();
    check("done hold flag", 256'(flag), 256'(1));
    do_read("ovfpack");

    // Ignored traffic: reads in IDLE/HAVE_A, bus noise during COMPUTE
    a = rand_mat(); b = rand_mat();
    en = 1'b1; rw = 1'b0; data_in = rand_mat(); tick(); en = 1'b0;
    write_a(a);
    en = 1'b1; rw = 1'b0; data_in = rand_mat(); tick(); en = 1'b0;
    write_b(b, 1'b0);
    wait_result("noise", 1'b1, model(a, b, 1'b0));
    do_read("noise");

    // Reset during second COMPUTE cycle
    a = rand_mat(); b = rand_mat();
    write_a(a); write_b(b, 1'b1);
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("midreset flag", 256'(flag), 256'(0));
    check("midreset data", data_out, 256'(0));
    repeat (6) tick();
    check("midreset flag stays low", 256'(flag), 256'(0));
    a = rand_mat(); b = rand_mat();
    write_a(a); write_b(b, 1'b1);
    wait_result("postreset", 1'b0, model(a, b, 1'b1));

    // Write in DONE without read starts a new A
    a2 = rand_mat();
    write_a(a2);
    check("done write flag", 256'(flag), 256'(0));
    write_b(b, 1'b0);
    wait_result("donewrite", 1'b0, model(a2, b, 1'b0));
    do_read("donewrite");

    // Randomized operations with idle gaps
    for (int n = 0; n < 12; n++) begin
      a = rand_mat(); b = rand_mat(); op = 1'($urandom);
      write_a(a);
      repeat ($urandom_range(0, 3)) tick();
      write_b(b, op);
      wait_result($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), model(a, b, op));
      repeat ($urandom_range(0, 2)) tick();
      do_read($sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
